q_acquire: RTL and testbench
============================

Q_ACQUIRE -- requirements
Module: q_acquire

Interface
REQ-001 The module SHALL have parameter BUS_WIDTH, default 10, giving the width of the ADC sample, i_ref and q_measured buses.
REQ-002 The module SHALL have parameter N_AVG_LOG2, default 3, where 2**N_AVG_LOG2 is the number of samples averaged per measurement.
REQ-003 The module SHALL have parameter SETTLE_CYCLES, default 16, giving the clock cycles to wait after an i_ref change before sampling.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port i_ref, input, BUS_WIDTH bits: the current reference driven by the bisection controller, watched for changes.
REQ-007 The module SHALL have port adc_valid, input, 1 bit: adc_data is valid this cycle.
REQ-008 The module SHALL have port adc_data, input, BUS_WIDTH bits, unsigned: the Q sample.
REQ-009 The module SHALL have port q_measured, output, BUS_WIDTH bits: the latest averaged Q.
REQ-010 The module SHALL have port ready, output, 1 bit: a level that is high once at least one measurement has completed since reset.
REQ-011 The module SHALL have port q_valid, output, 1 bit: a one-cycle pulse in each cycle where q_measured takes a new value.

Function
REQ-012 The module SHALL have FSM states SETTLE and ACQUIRE, and the state after reset SHALL be SETTLE.
REQ-013 The module SHALL register i_ref every cycle into i_ref_q, and a change is defined as (i_ref != i_ref_q) in a cycle.
REQ-014 In SETTLE, the module SHALL count exactly SETTLE_CYCLES cycles, ignore ADC samples, then move to ACQUIRE, and a change SHALL restart the count at 0.
REQ-015 In ACQUIRE, the module SHALL add each sample with adc_valid=1 into an unsigned accumulator of BUS_WIDTH+N_AVG_LOG2 bits, which cannot overflow.
REQ-016 Once the (2**N_AVG_LOG2)-th sample is accepted, the module SHALL in the next cycle load q_measured with the accumulator >> N_AVG_LOG2 (truncated), pulse q_valid for one cycle, and set ready.
REQ-017 After a completed measurement, the module SHALL clear the accumulator and sample counter and stay in ACQUIRE, re-measuring continuously.
REQ-018 A change in ACQUIRE SHALL discard the partial accumulation, send the FSM to SETTLE with count 0, and cause no q_valid pulse.
REQ-019 If a change coincides with the final accepted sample, the change SHALL win: the sample is discarded and q_measured is not updated.
REQ-020 ready SHALL stay high until reset, and q_measured SHALL hold its last value during SETTLE and during partial acquisitions.
REQ-021 Gaps in adc_valid SHALL only stretch ACQUIRE, with no timeout.

Reset
REQ-022 When rst=1 at a clock edge, the outputs SHALL be q_measured=0, ready=0 and q_valid=0, the accumulator, sample counter and settle counter SHALL be 0, the state SHALL be SETTLE, and i_ref_q SHALL be loaded from i_ref.
REQ-023 Reset SHALL take priority over every other event, including mid-ACQUIRE and a coincident final sample.

Structure
REQ-024 Package q_acquire_pkg SHALL hold the FSM state encoding and the default BUS_WIDTH, N_AVG_LOG2 and SETTLE_CYCLES constants, and be shared with the bisection controller.
REQ-025 The settle counter SHALL be a sub-module settle_timer with ports clk, rst, restart and done.
REQ-026 The accumulator, sample counter and FSM SHALL stay in q_acquire, with a total RTL size of roughly 150-250 lines.

Verification
Defaults apply; cycle 1 is the first cycle after rst is released.
REQ-027 Constant i_ref with adc_valid=1 and adc_data=100 on every cycle -> q_valid pulses in cycle 25, q_measured=100 and ready=1, repeating every 9 cycles.
REQ-028 Eight samples of 1023 -> q_measured=1023, and samples 0..7 -> q_measured=3 (28>>3, truncation).
REQ-029 i_ref changed after 4 accepted samples -> no q_valid pulse, 16 settle cycles follow, and q_measured keeps its prior value until the next full 8 samples.
REQ-030 adc_valid high on alternate cycles -> ACQUIRE lasts 15-16 cycles and the result equals the mean of the 8 accepted samples only.
REQ-031 rst pulsed mid-ACQUIRE after ready=1 -> the next cycle shows ready=0, q_measured=0 and state SETTLE, and the first new q_valid comes 25 cycles after release.
REQ-032 i_ref toggled at settle count 10 -> the settle count restarts, and ACQUIRE begins 16 cycles after the toggle.

Source files
------------

// File: rtl/q_acquire_pkg.sv
// Shared constants and FSM encoding for the Q acquisition path and the bisection controller.
package q_acquire_pkg;

  localparam int DEF_BUS_WIDTH     = 10;
  localparam int DEF_N_AVG_LOG2    = 3;
  localparam int DEF_SETTLE_CYCLES = 16;

  typedef enum logic {
    SETTLE  = 1'b0,
    ACQUIRE = 1'b1
  } acq_state_t;

endpackage

// File: rtl/settle_timer.sv
// Counts cycles since the last restart; done is high when the count reaches SETTLE_CYCLES-1.
// The count holds at done and returns to 0 on restart. No backpressure.
module settle_timer #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic done
);

  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  logic [CW-1:0] count;

  assign done = (int'(count) >= SETTLE_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      count <= '0;
    end else if (!done) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/q_acquire.sv
// Waits for i_ref to settle, averages 2**N_AVG_LOG2 valid ADC samples, and publishes the mean one cycle later.
// The ADC sample stream has no backpressure: samples are dropped while settling and in the publish cycle.
module q_acquire
  import q_acquire_pkg::*;
#(
  parameter int BUS_WIDTH     = DEF_BUS_WIDTH,
  parameter int N_AVG_LOG2    = DEF_N_AVG_LOG2,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] i_ref,
  input  logic                 adc_valid,
  input  logic [BUS_WIDTH-1:0] adc_data,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic                 ready,
  output logic                 q_valid
);

  localparam int ACC_W = BUS_WIDTH + N_AVG_LOG2;
  localparam int CNT_W = N_AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(2 ** N_AVG_LOG2);

  acq_state_t           state, state_n;
  logic [BUS_WIDTH-1:0] i_ref_q;
  logic [ACC_W-1:0]     acc, acc_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 change;
  logic                 full;
  logic                 load;
  logic                 settle_restart;
  logic                 settle_done;

  assign change         = (i_ref != i_ref_q);
  assign full           = (cnt == N_SAMPLES);
  assign settle_restart = (state != SETTLE) || change;

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk     (clk),
    .rst     (rst),
    .restart (settle_restart),
    .done    (settle_done)
  );

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    load    = 1'b0;
    case (state)
      SETTLE: begin
        acc_n = '0;
        cnt_n = '0;
        if (!change && settle_done) begin
          state_n = ACQUIRE;
        end
      end
      ACQUIRE: begin
        // A reference change beats everything, including a completed block of samples.
        if (change) begin
          state_n = SETTLE;
          acc_n   = '0;
          cnt_n   = '0;
        end else if (full) begin
          load  = 1'b1;
          acc_n = '0;
          cnt_n = '0;
        end else if (adc_valid) begin
          acc_n = acc + ACC_W'(adc_data);
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SETTLE;
      i_ref_q    <= i_ref;
      acc        <= '0;
      cnt        <= '0;
      q_measured <= '0;
      ready      <= 1'b0;
      q_valid    <= 1'b0;
    end else begin
      state   <= state_n;
      i_ref_q <= i_ref;
      acc     <= acc_n;
      cnt     <= cnt_n;
      q_valid <= load;
      if (load) begin
        q_measured <= acc[ACC_W-1:N_AVG_LOG2];
        ready      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_q_acquire.sv
// Directed bench for q_acquire: expected results are queued with their cycle, a monitor checks each q_valid pulse.
module tb_q_acquire;
  import q_acquire_pkg::*;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] i_ref = '0;
  logic         adc_valid = 1'b0;
  logic [W-1:0] adc_data = '0;
  logic [W-1:0] q_measured;
  logic         ready;
  logic         q_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int val;
    int cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  q_acquire dut (
    .clk        (clk),
    .rst        (rst),
    .i_ref      (i_ref),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .q_measured (q_measured),
    .ready      (ready),
    .q_valid    (q_valid)
  );

  always #5 clk = ~clk;

  // cyc = k during the cycle after the k-th rising edge with rst low
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    adc_valid = 1'b0;
    adc_data  = '1;
    repeat (n) step();
  endtask

  task automatic send(input int v);
    adc_valid = 1'b1;
    adc_data  = W'(v);
    step();
    adc_valid = 1'b0;
    adc_data  = '1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic expect_q(input int v, input int c);
    exp_t x;
    x.val = v;
    x.cyc = c;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    adc_valid = 1'b0;
    step();
    check("rst_q_measured", int'(q_measured), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_q_valid", int'(q_valid), 0);
    check("rst_state", int'(dut.state), int'(SETTLE));
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_q_valid: q_measured %0d at cycle %0d, no result expected", q_measured, cyc);
      end else begin
        e = exp_q.pop_front();
        check("q_value", int'(q_measured), e.val);
        check("q_cycle", cyc, e.cyc);
        check("q_ready", int'(ready), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // Constant stream of 100: first result at 25, then every 9 cycles
    do_reset();
    adc_valid = 1'b1;
    adc_data  = W'(100);
    expect_q(100, 25);
    expect_q(100, 34);
    expect_q(100, 43);
    wait_cyc(44);
    check("stream_ready", int'(ready), 1);
    check("stream_state", int'(dut.state), int'(ACQUIRE));

    // Reset in the middle of an acquisition clears everything
    do_reset();
    adc_valid = 1'b1;
    adc_data  = W'(100);
    expect_q(100, 25);
    wait_cyc(26);

    // Full-scale and truncation
    do_reset();
    wait_cyc(16);
    expect_q(1023, 25);
    repeat (8) send(1023);
    idle(1);
    expect_q(3, 34);
    for (int v = 0; v < 8; v++) send(v);
    idle(1);

    // Reference change after 4 samples: no result, 16 settle cycles, old value held
    repeat (4) send(500);
    i_ref = W'(5);
    idle(1);
    idle(15);
    check("chg_settle_state", int'(dut.state), int'(SETTLE));
    check("chg_hold_q", int'(q_measured), 3);
    idle(1);
    check("chg_acquire_state", int'(dut.state), int'(ACQUIRE));
    check("chg_ready", int'(ready), 1);
    expect_q(200, 64);
    repeat (8) send(200);
    idle(1);

    // Reference change on the final sample discards the block
    repeat (7) send(50);
    i_ref = W'(6);
    send(50);
    idle(16);
    check("coinc_state", int'(dut.state), int'(ACQUIRE));
    check("coinc_hold_q", int'(q_measured), 200);

    // Alternate-cycle samples 10..80 with junk data in the gaps: mean 45
    expect_q(45, 104);
    for (int k = 1; k <= 8; k++) begin
      send(10 * k);
      if (k < 8) idle(1);
    end
    idle(1);

    // Reference toggle at settle count 10 restarts settling
    do_reset();
    wait_cyc(10);
    i_ref = W'(9);
    step();
    wait_cyc(26);
    check("toggle_settle_state", int'(dut.state), int'(SETTLE));
    check("toggle_ready", int'(ready), 0);
    step();
    check("toggle_acquire_state", int'(dut.state), int'(ACQUIRE));
    expect_q(7, 36);
    repeat (8) send(7);
    idle(2);

    check("pending_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
